cpu_sequencer: RTL

Multi-cycle fetch/decode/execute sequencer for the 4-bit-opcode CPU core. It steps the datapath one state at a time and qualifies the level-type decode outputs into single-cycle enables. Decode outputs include reg_write, mem_read, mem_write, jump, branch_zero, branch_neg and halt. It also runs req/ack handshakes to instruction and data memory, retires instructions, and traps bus timeouts. It sits between the combinational decoder and the PC, IR, register-file and memory-interface logic.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/mem_wait_timer.sv | 41 ++++
 rtl/cpu_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared state encoding and opcode constants for the 4-bit CPU.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Opcode map shared with the decoder and the assembler bench
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_LD   = 4'b1001;
    localparam logic [3:0] OP_ST   = 4'b1010;
    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_BZ   = 4'b1100;
    localparam logic [3:0] OP_BN   = 4'b1101;
    localparam logic [3:0] OP_NOP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts cycles spent waiting for a memory ack; flags timeout.
// Revision : 1.0
// ============================================================================
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    output logic timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Any cycle that is not an unanswered wait restarts the count
    always_comb begin
        count_d = '0;
        if (wait_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = (TIMEOUT != 0) && wait_i && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle fetch/decode/execute sequencer with memory handshakes.
// Revision : 1.0
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RET_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             jump,
    input  logic             branch_zero,
    input  logic             branch_neg,
    input  logic             halt,
    input  logic             zero_flag,
    input  logic             neg_flag,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             rf_we,
    output logic             halted,
    output logic             bus_error,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired
);

    state_t           state_q;
    state_t           state_d;
    logic [RET_W-1:0] retired_q;

    logic w_imem_req;
    logic w_dmem_req;
    logic w_dmem_we;
    logic w_ir_load;
    logic w_pc_inc;
    logic w_pc_load;
    logic w_rf_we;
    logic w_halted;
    logic w_bus_error;
    logic w_waiting;
    logic w_timeout;

    assign w_waiting = ((state_q == ST_FETCH) && !imem_ack) ||
                       ((state_q == ST_MEM)   && !dmem_ack);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .wait_i    (w_waiting),
        .timeout_o (w_timeout)
    );

    always_comb begin
        state_d     = state_q;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_rf_we     = 1'b0;
        w_halted    = 1'b0;
        w_bus_error = 1'b0;

        case (state_q)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_load = 1'b1;
                    state_d   = ST_DECODE;
                end else if (w_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                state_d = halt ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                if (jump || (branch_zero && zero_flag) || (branch_neg && neg_flag)) begin
                    w_pc_load = 1'b1;
                    state_d   = ST_FETCH;
                end else if (branch_zero || branch_neg) begin
                    w_pc_inc = 1'b1;
                    state_d  = ST_FETCH;
                end else if (mem_read || mem_write) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = mem_write;
                if (dmem_ack) begin
                    // A store has nothing to write back, so it retires here
                    if (mem_read) begin
                        state_d = ST_WB;
                    end else begin
                        w_pc_inc = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (w_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                w_rf_we  = reg_write;
                w_pc_inc = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALTED: begin
                w_halted = 1'b1;
                if (start) begin
                    w_pc_inc = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_ERROR: begin
                w_bus_error = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_pc_inc || w_pc_load) begin
                retired_q <= retired_q + RET_W'(1);
            end
        end
    end

    // Strobes are held low while reset is asserted
    assign imem_req  = w_imem_req  & ~rst;
    assign dmem_req  = w_dmem_req  & ~rst;
    assign dmem_we   = w_dmem_we   & ~rst;
    assign ir_load   = w_ir_load   & ~rst;
    assign pc_inc    = w_pc_inc    & ~rst;
    assign pc_load   = w_pc_load   & ~rst;
    assign rf_we     = w_rf_we     & ~rst;
    assign halted    = w_halted    & ~rst;
    assign bus_error = w_bus_error & ~rst;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule
`default_nettype wire
